if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- MIPS-style instruction fetch stage.
//
// Holds the PC, selects the next PC (sequential / branch / jump / jr),
// presents the PC to a combinational instruction memory and latches the
// returned word into the IF/ID pipeline register together with PC+4.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined   : on a redirect the sequentially fetched instruction is kept
//               as a delay slot (valid, counted).
//   undefined : on a redirect IF/ID is flushed to a bubble (not counted).
//
// Pipeline handshake: there is no valid/ready pair here. in_stall is the
// only back-pressure: while it is high nothing advances, and it takes
// priority over any redirect requested in the same cycle.
// out_if_id_valid marks IF/ID as holding a real instruction (0 = bubble).
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_stall,
  input  logic [1:0]  in_pc_sel,
  input  logic [31:0] in_branch_target,
  input  logic [31:0] in_jump_target,
  input  logic [31:0] in_jr_target,
  output logic [31:0] out_imem_addr,
  input  logic [31:0] in_imem_data,
  output logic [31:0] out_pc,
  output logic [31:0] out_if_id_instruction,
  output logic [31:0] out_if_id_pc4,
  output logic        out_if_id_valid,
  output logic [31:0] out_fetch_count
);

  // Bubble encoding: sll $0,$0,0 with a zero PC+4.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_PC4   = 32'h0000_0000;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_count;

  logic [31:0] w_pc4;
  logic [31:0] w_sel_target;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_load_valid;

  // PC+4 wraps naturally modulo 2^32.
  assign w_pc4        = r_pc + 32'd4;
  assign w_redirect   = (in_pc_sel != 2'b00);
  // A redirect keeps the fetched word only when delay slots are enabled.
  assign w_load_valid = !w_redirect || DELAY_SLOT;

  // Next-PC mux; the low two bits are forced to zero to keep word alignment.
  always_comb begin
    w_sel_target = w_pc4;
    case (in_pc_sel)
      2'b00:   w_sel_target = w_pc4;
      2'b01:   w_sel_target = in_branch_target;
      2'b10:   w_sel_target = in_jump_target;
      2'b11:   w_sel_target = in_jr_target;
      default: w_sel_target = w_pc4;
    endcase
    w_next_pc = {w_sel_target[31:2], 2'b00};
  end

  // PC, IF/ID register and fetch counter; stall freezes everything.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= BUBBLE_INSTR;
      r_pc4   <= BUBBLE_PC4;
      r_valid <= 1'b0;
      r_count <= 32'd0;
    end else if (!in_stall) begin
      r_pc <= w_next_pc;
      if (w_load_valid) begin
        r_instr <= in_imem_data;
        r_pc4   <= w_pc4;
        r_valid <= 1'b1;
        r_count <= r_count + 32'd1;
      end else begin
        r_instr <= BUBBLE_INSTR;
        r_pc4   <= BUBBLE_PC4;
        r_valid <= 1'b0;
      end
    end
  end

  assign out_imem_addr         = r_pc;
  assign out_pc                = r_pc;
  assign out_if_id_instruction = r_instr;
  assign out_if_id_pc4         = r_pc4;
  assign out_if_id_valid       = r_valid;
  assign out_fetch_count       = r_count;

endmodule
